// File: rtl/router_reg_p.sv
// Router datapath register block: header/payload staging toward the FIFO, running
// parity and payload count, and end-of-packet parity/length error reporting.
module router_reg_p #(
  parameter int unsigned DW         = 8,
  parameter int unsigned ADDRW      = 2,
  parameter int unsigned ODD_PARITY = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pkt_valid,
  input  logic          fifo_full,
  input  logic          detect_addr,
  input  logic          lfd_state,
  input  logic          ld_state,
  input  logic          laf_state,
  input  logic          full_state,
  input  logic          rst_int_reg,
  input  logic [DW-1:0] data_in,
  output logic [DW-1:0] dout,
  output logic          err,
  output logic          len_err,
  output logic          parity_done,
  output logic          low_pktvalid
);

  localparam int unsigned      CW       = DW - ADDRW;
  localparam logic [DW-1:0]    PAR_MASK = (ODD_PARITY != 0) ? '1 : '0;

  logic [DW-1:0] r_dout, r_hold, r_hdr, r_int_par, r_pkt_par;
  logic [CW-1:0] r_cnt;
  logic          r_err, r_len_err, r_parity_done, r_pd_q, r_low_pktvalid;

  logic w_ld_acc, w_pd_ld, w_pd_laf;

  // Payload bytes that count toward parity and length.
  assign w_ld_acc = ld_state && pkt_valid && !full_state;
  // Parity byte arrives either directly, or parked in hold_reg behind a full FIFO.
  assign w_pd_ld  = ld_state && !fifo_full && !pkt_valid;
  assign w_pd_laf = laf_state && r_low_pktvalid && !r_parity_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dout         <= '0;
      r_hold         <= '0;
      r_hdr          <= '0;
      r_int_par      <= '0;
      r_pkt_par      <= '0;
      r_cnt          <= '0;
      r_err          <= 1'b0;
      r_len_err      <= 1'b0;
      r_parity_done  <= 1'b0;
      r_pd_q         <= 1'b0;
      r_low_pktvalid <= 1'b0;
    end else begin
      if (detect_addr && pkt_valid) r_hdr <= data_in;

      if (lfd_state)                   r_dout <= r_hdr;
      else if (ld_state && !fifo_full) r_dout <= data_in;
      else if (laf_state)              r_dout <= r_hold;

      if (ld_state && fifo_full) r_hold <= data_in;

      if (detect_addr)    r_int_par <= '0;
      else if (lfd_state) r_int_par <= r_int_par ^ r_hdr;
      else if (w_ld_acc)  r_int_par <= r_int_par ^ data_in;

      if (detect_addr)                     r_cnt <= '0;
      else if (w_ld_acc && (r_cnt != '1))  r_cnt <= r_cnt + 1'b1;

      if (w_pd_ld)       r_pkt_par <= data_in;
      else if (w_pd_laf) r_pkt_par <= r_hold;

      if (detect_addr)              r_parity_done <= 1'b0;
      else if (w_pd_ld || w_pd_laf) r_parity_done <= 1'b1;
      r_pd_q <= r_parity_done;

      if (ld_state && !pkt_valid) r_low_pktvalid <= 1'b1;
      else if (rst_int_reg)       r_low_pktvalid <= 1'b0;

      // Verdict is taken once, one cycle after parity_done rises, then held.
      if (detect_addr) begin
        r_err     <= 1'b0;
        r_len_err <= 1'b0;
      end else if (r_parity_done && !r_pd_q) begin
        r_err     <= (r_int_par ^ PAR_MASK) != r_pkt_par;
        r_len_err <= r_cnt != r_hdr[DW-1:ADDRW];
      end
    end
  end

  assign dout         = r_dout;
  assign err          = r_err;
  assign len_err      = r_len_err;
  assign parity_done  = r_parity_done;
  assign low_pktvalid = r_low_pktvalid;

endmodule

// File: tb/tb_router_reg_p.sv
// Bench for router_reg_p: even- and odd-parity instances share one stimulus stream;
// expectations come from packet-level arithmetic (xor of bytes, saturated byte count).
module tb_router_reg_p;

  logic       clk = 1'b0;
  logic       reset, pkt_valid, fifo_full, detect_addr, lfd_state, ld_state;
  logic       laf_state, full_state, rst_int_reg;
  logic [7:0] data_in;
  logic [7:0] dout_e, dout_o;
  logic       err_e, err_o, len_e, len_o, pd_e, pd_o, lpv_e, lpv_o;

  always #5 clk = ~clk;

  router_reg_p #(.DW(8), .ADDRW(2), .ODD_PARITY(0)) u_even (
    .clk(clk), .reset(reset), .pkt_valid(pkt_valid), .fifo_full(fifo_full),
    .detect_addr(detect_addr), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
    .data_in(data_in), .dout(dout_e), .err(err_e), .len_err(len_e),
    .parity_done(pd_e), .low_pktvalid(lpv_e));

  router_reg_p #(.DW(8), .ADDRW(2), .ODD_PARITY(1)) u_odd (
    .clk(clk), .reset(reset), .pkt_valid(pkt_valid), .fifo_full(fifo_full),
    .detect_addr(detect_addr), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
    .data_in(data_in), .dout(dout_o), .err(err_o), .len_err(len_o),
    .parity_done(pd_o), .low_pktvalid(lpv_o));

  int         n_chk = 0, n_pass = 0;
  logic [7:0] pay [0:79];
  logic [7:0] e_dout;
  logic       e_err_e, e_err_o, e_len, e_pd, e_lpv;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".dout_e"}, 32'(dout_e), 32'(e_dout));
    chk({tag, ".dout_o"}, 32'(dout_o), 32'(e_dout));
    chk({tag, ".pd_e"},   32'(pd_e),   32'(e_pd));
    chk({tag, ".pd_o"},   32'(pd_o),   32'(e_pd));
    chk({tag, ".lpv_e"},  32'(lpv_e),  32'(e_lpv));
    chk({tag, ".lpv_o"},  32'(lpv_o),  32'(e_lpv));
    chk({tag, ".err_e"},  32'(err_e),  32'(e_err_e));
    chk({tag, ".err_o"},  32'(err_o),  32'(e_err_o));
    chk({tag, ".len_e"},  32'(len_e),  32'(e_len));
    chk({tag, ".len_o"},  32'(len_o),  32'(e_len));
  endtask

  task automatic clr_ctl();
    reset = 0; pkt_valid = 0; fifo_full = 0; detect_addr = 0; lfd_state = 0;
    ld_state = 0; laf_state = 0; full_state = 0; rst_int_reg = 0;
  endtask

  task automatic exp_zero();
    e_dout = 0; e_err_e = 0; e_err_o = 0; e_len = 0; e_pd = 0; e_lpv = 0;
  endtask

  function automatic logic [7:0] pxor(input logic [7:0] h, input int n);
    logic [7:0] x;
    x = h;
    for (int i = 0; i < n; i++) x ^= pay[i];
    return x;
  endfunction

  // One packet: header, n payload bytes, parity byte. full_idx selects which byte
  // (n = the parity byte) meets a full FIFO; -1 for none.
  task automatic send_pkt(input string tag, input logic [7:0] h, input int n,
                          input logic [7:0] par, input int full_idx);
    logic [7:0] xr;
    int         cnt;
    xr  = pxor(h, n);
    cnt = (n > 63) ? 63 : n;
    clr_ctl(); detect_addr = 1; pkt_valid = 1; data_in = h; tick();
    e_pd = 0; e_err_e = 0; e_err_o = 0; e_len = 0;
    chk_all({tag, ".detect"});
    detect_addr = 0; lfd_state = 1; data_in = 8'($urandom); tick();
    e_dout = h; chk_all({tag, ".lfd"});
    lfd_state = 0;
    for (int i = 0; i < n; i++) begin
      ld_state = 1; data_in = pay[i]; fifo_full = (i == full_idx); tick();
      if (i == full_idx) begin
        chk_all({tag, ".ld_full"});
        ld_state = 0; fifo_full = 0; full_state = 1; data_in = 8'($urandom); tick();
        chk_all({tag, ".full"});
        full_state = 0; laf_state = 1; tick();
        e_dout = pay[i]; chk_all({tag, ".laf"});
        laf_state = 0;
      end else if (i < 8 || i == n - 1) begin
        e_dout = pay[i]; chk_all({tag, ".ld"});
      end else begin
        e_dout = pay[i]; chk({tag, ".ld_dout"}, 32'(dout_e), 32'(e_dout));
      end
    end
    ld_state = 1; pkt_valid = 0; data_in = par; fifo_full = (full_idx == n); tick();
    e_lpv = 1;
    if (full_idx == n) begin
      chk_all({tag, ".par_full"});
      ld_state = 0; fifo_full = 0; full_state = 1; data_in = 8'($urandom); tick();
      chk_all({tag, ".par_fullst"});
      full_state = 0; laf_state = 1; tick();
      e_dout = par; e_pd = 1; chk_all({tag, ".par_laf"});
    end else begin
      e_dout = par; e_pd = 1; chk_all({tag, ".par"});
    end
    clr_ctl(); rst_int_reg = 1; tick();
    e_lpv = 0; e_err_e = (xr != par); e_err_o = (~xr != par);
    e_len = (cnt != int'(h[7:2]));
    chk_all({tag, ".eval"});
    rst_int_reg = 0; tick(); tick();
    chk_all({tag, ".hold"});
  endtask

  initial begin
    logic [7:0] h, x, par;
    int         n, fi, len;
    clr_ctl(); data_in = 0; exp_zero();

    // Reset with random inputs.
    for (int c = 0; c < 2; c++) begin
      reset = 1; pkt_valid = 1'($urandom); fifo_full = 1'($urandom);
      detect_addr = 1'($urandom); lfd_state = 1'($urandom); ld_state = 1'($urandom);
      laf_state = 1'($urandom); full_state = 1'($urandom); rst_int_reg = 1'($urandom);
      data_in = 8'($urandom); tick();
      chk_all("reset");
    end
    clr_ctl(); tick(); chk_all("post_reset");

    // Good packet, then bad parity.
    for (int i = 0; i < 8; i++) pay[i] = 8'($urandom);
    x = pxor(8'h21, 8);
    send_pkt("good", 8'h21, 8, x, -1);
    send_pkt("badpar", 8'h21, 8, x ^ 8'h01, -1);

    // FIFO full on payload byte 0x5A.
    for (int i = 0; i < 8; i++) pay[i] = 8'($urandom);
    pay[3] = 8'h5A;
    send_pkt("fifofull", 8'h21, 8, pxor(8'h21, 8), 3);

    // Parity byte meeting a full FIFO.
    send_pkt("parfull", 8'h21, 8, pxor(8'h21, 8), 8);

    // Length error: header says 16, 15 bytes sent.
    for (int i = 0; i < 15; i++) pay[i] = 8'($urandom);
    send_pkt("lenerr", 8'h41, 15, pxor(8'h41, 15), -1);

    // Odd parity byte: odd instance must report clean.
    for (int i = 0; i < 8; i++) pay[i] = 8'($urandom);
    send_pkt("oddpar", 8'h21, 8, ~pxor(8'h21, 8), -1);

    // Count saturation: 70 bytes against a length field of 63.
    for (int i = 0; i < 70; i++) pay[i] = 8'($urandom);
    send_pkt("sat", 8'hFE, 70, pxor(8'hFE, 70), -1);

    // Randomized packets.
    for (int k = 0; k < 6; k++) begin
      n   = int'($urandom_range(1, 20));
      len = ($urandom_range(0, 1) != 0) ? n : int'($urandom_range(0, 63));
      h   = {6'(len), 2'($urandom)};
      for (int i = 0; i < n; i++) pay[i] = 8'($urandom);
      x   = pxor(h, n);
      case ($urandom_range(0, 2))
        0:       par = x;
        1:       par = ~x;
        default: par = 8'($urandom);
      endcase
      fi = int'($urandom_range(0, n + 3));
      if (fi > n) fi = -1;
      send_pkt("rand", h, n, par, fi);
    end

    // Mid-packet reset after payload byte 4.
    for (int i = 0; i < 8; i++) pay[i] = 8'($urandom);
    clr_ctl(); detect_addr = 1; pkt_valid = 1; data_in = 8'h21; tick();
    detect_addr = 0; lfd_state = 1; tick();
    lfd_state = 0; ld_state = 1;
    for (int i = 0; i < 4; i++) begin
      data_in = pay[i]; tick();
      chk("midrst.ld", 32'(dout_o), 32'(pay[i]));
    end
    reset = 1; data_in = 8'($urandom); tick();
    exp_zero(); chk_all("midrst.reset");
    clr_ctl(); tick(); chk_all("midrst.after");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
